// File: rtl/spmmio_arbiter.sv
// Purpose: two-master arbiter in front of one spmmio slave. Master 0 is the CPU and
//          master 1 is debug/DMA. Grants alternate on ties, and a granted master
//          keeps the bus until it drops cyc.
// Latency: a grant takes effect one cycle after IDLE sees the request. Once granted,
//          the slave path and the response path are purely combinational.
// Backpressure: the slave stalls by holding ack low. A stall of timeout_cycles cycles
//          ends in a one-cycle err pulse to the owning master.
// Ports:
//   clk, reset                   - clock; asynchronous active-high reset
//   mN_adr/sel/we/dat/cyc/stb_i  - bus request from master N
//   mN_ack/err/dat_o             - response to master N (held at 0 unless N is granted)
//   s_adr/sel/we/dat/cyc/stb_o   - request to the shared slave, taken from the granted master
//   s_ack_i, s_dat_i             - slave response
//   gnt                          - one-hot-or-zero grant; gnt[0] = master 0, gnt[1] = master 1
module spmmio_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [23:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [23:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [15:0] wdog_limit = 16'(timeout_cycles - 1);

  state_t      state, state_nxt;
  logic        last_gnt, last_gnt_nxt;
  logic [15:0] wdog, wdog_nxt;

  logic [23:0] sel_adr;
  logic [3:0]  sel_sel;
  logic        sel_we;
  logic [31:0] sel_dat;
  logic        sel_cyc;
  logic        sel_stb;
  logic        timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;   // master 0 wins the first tie after reset
      wdog     <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      wdog     <= wdog_nxt;
    end
  end

  // Arbitration: no preemption. last_gnt is updated when a master gives up the bus.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_gnt ? GRANT0 : GRANT1;
        else if (m0_cyc_i)        state_nxt = GRANT0;
        else if (m1_cyc_i)        state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!m0_cyc_i) begin
          last_gnt_nxt = 1'b0;
          state_nxt    = m1_cyc_i ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!m1_cyc_i) begin
          last_gnt_nxt = 1'b1;
          state_nxt    = m0_cyc_i ? GRANT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request mux. In IDLE everything stays 0, so the slave sees no stb
  // from a master that has not been granted.
  always_comb begin
    sel_adr = '0;
    sel_sel = '0;
    sel_we  = 1'b0;
    sel_dat = '0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    case (state)
      GRANT0: begin
        sel_adr = m0_adr_i; sel_sel = m0_sel_i; sel_we = m0_we_i;
        sel_dat = m0_dat_i; sel_cyc = m0_cyc_i; sel_stb = m0_stb_i;
      end
      GRANT1: begin
        sel_adr = m1_adr_i; sel_sel = m1_sel_i; sel_we = m1_we_i;
        sel_dat = m1_dat_i; sel_cyc = m1_cyc_i; sel_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  // The timeout fires only while ack is low, so a late ack in the limit cycle
  // still completes normally. ack and err can therefore never both be high.
  assign timeout = sel_stb && !s_ack_i && (wdog == wdog_limit);

  // The watchdog restarts on ack, on an idle strobe, on a timeout, or when the
  // grant is about to change (this also covers a master that abandons a stalled transfer).
  always_comb begin
    if ((state_nxt != state) || !sel_stb || s_ack_i || timeout) wdog_nxt = '0;
    else                                                       wdog_nxt = wdog + 16'd1;
  end

  assign s_adr_o = sel_adr;
  assign s_sel_o = sel_sel;
  assign s_we_o  = sel_we;
  assign s_dat_o = sel_dat;
  assign s_cyc_o = sel_cyc;
  assign s_stb_o = sel_stb && !timeout;

  assign gnt = {state == GRANT1, state == GRANT0};

  assign m0_ack_o = (state == GRANT0) && s_ack_i;
  assign m0_err_o = (state == GRANT0) && timeout;
  assign m0_dat_o = (state == GRANT0) ? s_dat_i : '0;
  assign m1_ack_o = (state == GRANT1) && s_ack_i;
  assign m1_err_o = (state == GRANT1) && timeout;
  assign m1_dat_o = (state == GRANT1) ? s_dat_i : '0;

endmodule

// File: tb/tb_spmmio_arbiter.sv
`timescale 1ns/1ps
module tb_spmmio_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_we_i, m1_we_i, s_we_o;
  logic [31:0] m0_dat_i, m1_dat_i, s_dat_o, s_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, s_cyc_o, s_stb_o, s_ack_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [1:0]  gnt;

  always #5 clk = ~clk;

  spmmio_arbiter #(.timeout_cycles(T)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .gnt(gnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: owner of the bus (-1 = nobody), the master that most
  // recently gave the bus up, and the number of consecutive stalled cycles
  // already spent by the owner's current strobe.
  int owner;
  int last;
  int stalled;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic owner_cyc(input int who);
    return (who == 0) ? m0_cyc_i : (who == 1) ? m1_cyc_i : 1'b0;
  endfunction

  function automatic logic owner_stb(input int who);
    return (who == 0) ? m0_stb_i : (who == 1) ? m1_stb_i : 1'b0;
  endfunction

  // A timeout happens when this cycle would be the T-th stalled cycle in a row.
  function automatic logic model_timeout();
    return owner_stb(owner) && !s_ack_i && (stalled + 1 == T);
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; stalled = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [23:0] e_adr; logic [3:0] e_sel; logic e_we; logic [31:0] e_dat;
    logic e_cyc, e_stb, tmo;
    logic [1:0] e_gnt;
    e_adr = '0; e_sel = '0; e_we = 1'b0; e_dat = '0; e_cyc = 1'b0; e_stb = 1'b0;
    if (owner == 0) begin
      e_adr = m0_adr_i; e_sel = m0_sel_i; e_we = m0_we_i; e_dat = m0_dat_i;
      e_cyc = m0_cyc_i; e_stb = m0_stb_i;
    end else if (owner == 1) begin
      e_adr = m1_adr_i; e_sel = m1_sel_i; e_we = m1_we_i; e_dat = m1_dat_i;
      e_cyc = m1_cyc_i; e_stb = m1_stb_i;
    end
    tmo = model_timeout();
    if (tmo) e_stb = 1'b0;
    e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    chk({tag, "_gnt"},   gnt,     e_gnt);
    chk({tag, "_sadr"},  s_adr_o, e_adr);
    chk({tag, "_ssel"},  s_sel_o, e_sel);
    chk({tag, "_swe"},   s_we_o,  e_we);
    chk({tag, "_sdat"},  s_dat_o, e_dat);
    chk({tag, "_scyc"},  s_cyc_o, e_cyc);
    chk({tag, "_sstb"},  s_stb_o, e_stb);
    chk({tag, "_m0ack"}, m0_ack_o, (owner == 0) && s_ack_i);
    chk({tag, "_m0err"}, m0_err_o, (owner == 0) && tmo);
    chk({tag, "_m0dat"}, m0_dat_o, (owner == 0) ? s_dat_i : 32'h0);
    chk({tag, "_m1ack"}, m1_ack_o, (owner == 1) && s_ack_i);
    chk({tag, "_m1err"}, m1_err_o, (owner == 1) && tmo);
    chk({tag, "_m1dat"}, m1_dat_o, (owner == 1) ? s_dat_i : 32'h0);
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_advance();
    int nxt;
    logic stall_now;
    logic tmo;
    stall_now = owner_stb(owner) && !s_ack_i;
    tmo = model_timeout();
    nxt = owner;
    if (owner < 0) begin
      if (m0_cyc_i && m1_cyc_i) nxt = 1 - last;
      else if (m0_cyc_i)        nxt = 0;
      else if (m1_cyc_i)        nxt = 1;
    end else if (!owner_cyc(owner)) begin
      last = owner;
      nxt = owner_cyc(1 - owner) ? 1 - owner : -1;
    end
    if (nxt != owner)          stalled = 0;
    else if (stall_now && !tmo) stalled = stalled + 1;
    else                        stalled = 0;
    owner = nxt;
  endtask

  // One bus cycle: check at the falling edge, then cross the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_adr_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_dat_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_dat_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i = 1'b0; s_dat_i = '0;
    model_reset();

    // Reset takes effect without a clock edge. All outputs must be 0 even while the masters drive requests.
    #1 reset = 1'b1;
    #1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h123456; s_ack_i = 1'b1; s_dat_i = 32'hA5A5A5A5;
    #1;
    check_outputs("reset");
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Simultaneous request after reset: master 0 wins, then master 1 follows.
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    step("tie_idle");
    chk("tie_gnt_m0", gnt, 2'b01);
    m0_cyc_i = 1'b0;
    step("tie_m0_drop");
    chk("handover_gnt_m1", gnt, 2'b10);

    // Master 1 holds the bus for 10 acked transfers while master 0 waits.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m1_stb_i = 1'b1; m1_adr_i = 24'(i); m1_dat_i = $urandom; s_ack_i = 1'b1; s_dat_i = $urandom;
      #1;
      chk("hold_gnt_m1", gnt, 2'b10);
      chk("hold_m0_ack_zero", m0_ack_o, 1'b0);
      step("hold");
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    step("m1_release");
    chk("after_release_gnt_m0", gnt, 2'b01);

    // Master 0 write acked in the same cycle.
    m0_adr_i = 24'h030010; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF; m0_we_i = 1'b1;
    s_ack_i = 1'b1; s_dat_i = 32'h0;
    #1;
    chk("wr_sadr", s_adr_o, 24'h030010);
    chk("wr_sdat", s_dat_o, 32'hDEADBEEF);
    chk("wr_ssel", s_sel_o, 4'hF);
    chk("wr_swe", s_we_o, 1'b1);
    chk("wr_sstb", s_stb_o, 1'b1);
    chk("wr_m0ack", m0_ack_o, 1'b1);
    step("wr");

    // Stall: err in the 4th stalled cycle with stb masked. The held strobe then starts a fresh count.
    s_ack_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("stall_m0err", m0_err_o, (k % 4) == 0);
      chk("stall_sstb", s_stb_o, (k % 4) != 0);
      step("stall");
    end

    // Ack arriving exactly in the 4th stalled cycle wins over the timeout.
    for (int k = 1; k <= 4; k++) begin
      s_ack_i = (k == 4);
      #1;
      chk("late_ack_m0ack", m0_ack_o, k == 4);
      chk("late_ack_m0err", m0_err_o, 1'b0);
      step("late_ack");
    end
    s_ack_i = 1'b0;

    // Move to master 1, stall briefly, then reset mid-transfer.
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step("to_m1");
    chk("to_m1_gnt", gnt, 2'b10);
    step("m1_stall1");
    step("m1_stall2");
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_gnt", gnt, 2'b00);
    chk("async_rst_scyc", s_cyc_o, 1'b0);
    chk("async_rst_m1err", m1_err_o, 1'b0);
    check_outputs("async_rst");
    @(posedge clk); #1 reset = 1'b0;
    m0_cyc_i = 1'b1;
    step("post_rst_tie");
    chk("post_rst_gnt_m0", gnt, 2'b01);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_adr_i = 24'($urandom); m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = 24'($urandom); m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
